// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Declarations shared by the UART blocks.
//   rx_state_e : receive FSM state encoding (3 bits)
//   PAR_EVEN / PAR_ODD : parity-type select values, shared with the TX side
//   maj3       : 2-of-3 majority vote, used for oversampled bit decisions
// ----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4
   } rx_state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// ----------------------------------------------------------------------------
// uart_rx_sampler
// Takes three samples of RX_IN around the middle of each bit period and
// presents their majority.
//   clk, rst    : clock, asynchronous active-high reset
//   edge_cnt    : position within the current bit (0..PRESCALE-1)
//   RX_IN       : serial line, synchronous to clk
//   sampled_bit : 2-of-3 majority of the three mid-bit samples; only
//                 meaningful while sample_done is high
//   sample_done : high during the cycle of the third sample
// ----------------------------------------------------------------------------
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int unsigned PRESCALE = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [$clog2(PRESCALE)-1:0] edge_cnt,
   input  logic                        RX_IN,
   output logic                        sampled_bit,
   output logic                        sample_done
);

   localparam int unsigned CW = $clog2(PRESCALE);
   localparam logic [CW-1:0] E_FIRST = CW'(PRESCALE / 2 - 1);
   localparam logic [CW-1:0] E_MID   = CW'(PRESCALE / 2);
   localparam logic [CW-1:0] E_LAST  = CW'(PRESCALE / 2 + 1);

   logic s0;
   logic s1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0 <= 1'b1;
         s1 <= 1'b1;
      end else begin
         if (edge_cnt == E_FIRST) s0 <= RX_IN;
         if (edge_cnt == E_MID)   s1 <= RX_IN;
      end
   end

   // Third sample is taken live so the vote is ready in the same cycle.
   assign sample_done = (edge_cnt == E_LAST);
   assign sampled_bit = maj3(s0, s1, RX_IN);

endmodule

// File: rtl/uart_rx_fsm.sv
// ----------------------------------------------------------------------------
// uart_rx_fsm
// UART receive controller: start-bit detection with glitch rejection,
// majority-voted data bits (LSB first), optional parity and stop check.
//   clk, rst   : clock, asynchronous active-high reset
//   RX_IN      : serial line (idles high), synchronous to clk
//   PAR_EN     : a parity bit follows the data bits (latched per frame)
//   PAR_TYP    : 0 even, 1 odd parity (latched per frame)
//   P_DATA     : last good received word, held until the next good frame
//   data_valid : one-cycle pulse, P_DATA updated this cycle
//   par_err    : one-cycle pulse, parity mismatch
//   stp_err    : one-cycle pulse, stop bit sampled low
//   rx_busy    : high whenever the FSM is not idle
// ----------------------------------------------------------------------------
module uart_rx_fsm
   import uart_pkg::*;
#(
   parameter int unsigned PRESCALE   = 8,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  RX_IN,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err,
   output logic                  rx_busy
);

   localparam int unsigned CW = $clog2(PRESCALE);
   localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] E_END    = CW'(PRESCALE - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

   rx_state_e             state;
   logic [CW-1:0]         edge_cnt;
   logic [BW-1:0]         bit_cnt;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic                  par_en_l;
   logic                  par_typ_l;
   logic                  par_bad;
   logic                  bit_val;
   logic                  maj_bit;
   logic                  sample_done;
   logic                  bit_end;

   uart_rx_sampler #(
      .PRESCALE(PRESCALE)
   ) u_sampler (
      .clk        (clk),
      .rst        (rst),
      .edge_cnt   (edge_cnt),
      .RX_IN      (RX_IN),
      .sampled_bit(maj_bit),
      .sample_done(sample_done)
   );

   assign bit_end = (edge_cnt == E_END);
   assign rx_busy = (state != RX_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= RX_IDLE;
         edge_cnt   <= '0;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         par_en_l   <= 1'b0;
         par_typ_l  <= PAR_EVEN;
         par_bad    <= 1'b0;
         bit_val    <= 1'b1;
         P_DATA     <= '0;
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;

         if (sample_done) bit_val <= maj_bit;

         if (state != RX_IDLE) edge_cnt <= bit_end ? '0 : edge_cnt + 1'b1;

         case (state)
            RX_IDLE: begin
               // The detection cycle is edge 0 of the start bit.
               if (!RX_IN) begin
                  state     <= RX_START;
                  edge_cnt  <= CW'(1);
                  bit_cnt   <= '0;
                  par_en_l  <= PAR_EN;
                  par_typ_l <= PAR_TYP;
                  par_bad   <= 1'b0;
                  shift_reg <= '0;
               end
            end
            RX_START: begin
               if (bit_end) state <= bit_val ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
               if (bit_end) begin
                  shift_reg[bit_cnt] <= bit_val;
                  if (bit_cnt == LAST_BIT) begin
                     bit_cnt <= '0;
                     state   <= par_en_l ? RX_PARITY : RX_STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            RX_PARITY: begin
               if (bit_end) begin
                  par_bad <= bit_val != ((^shift_reg) ^ (par_typ_l == PAR_ODD));
                  state   <= RX_STOP;
               end
            end
            RX_STOP: begin
               if (bit_end) begin
                  state <= RX_IDLE;
                  if (!bit_val) stp_err <= 1'b1;
                  if (par_bad)  par_err <= 1'b1;
                  if (bit_val && !par_bad) begin
                     data_valid <= 1'b1;
                     P_DATA     <= shift_reg;
                  end
               end
            end
            default: state <= RX_IDLE;
         endcase
      end
   end

endmodule
